adc_dout_emulator: RTL and testbench

- Transmit side of the 8-channel, 4-lane ADC serial data-output interface (DRDY/DCLK/DOUT0..3) that the existing ADC reader block consumes.
- Serialises eight 24-bit samples per frame, one frame per accepted tick.
- Used as an on-board loopback source: pmoda_o drives the pmodb_i pins. Lets the QPD/OPD chains be exercised without the real ADC.

---
 rtl/adc_dout_emulator.sv | 207 ++++++++++++++++++++
 tb/tb_adc_dout_emulator.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dout_emulator.sv
// adc_dout_emulator
// Transmit side of the 8-channel, 4-lane ADC serial data-output interface
// (DRDY/DCLK/DOUT0..3). Each accepted tick captures eight 24-bit samples and
// serialises them as one frame: lane k carries channel 2k+1 then channel 2k+2,
// each as a 32-bit word {5'b0, idx[2:0], data[23:0]}, MSB first. DOUT and DRDY
// change on DCLK falling edges so the receiver can sample on rising edges.
module adc_dout_emulator #(
    parameter int unsigned CLK_DIV  = 4,   // clk cycles per DCLK half-period, 2..255
    parameter int unsigned GAP_DCLK = 4    // idle DCLK periods after each frame, 0..255
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               tick_i,
    input  logic signed [23:0] ch1_i,
    input  logic signed [23:0] ch2_i,
    input  logic signed [23:0] ch3_i,
    input  logic signed [23:0] ch4_i,
    input  logic signed [23:0] ch5_i,
    input  logic signed [23:0] ch6_i,
    input  logic signed [23:0] ch7_i,
    input  logic signed [23:0] ch8_i,
    output logic               ready_o,
    output logic               drdy_o,
    output logic               dclk_o,
    output logic [3:0]         dout_o,
    output logic               overrun_o,
    output logic [31:0]        frames_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_INIT = 8'(GAP_DCLK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SHIFT,
        ST_GAP
    } state_e;

    // DCLK generator
    logic [7:0] div_cnt_q, div_cnt_d;
    logic       dclk_q, dclk_d;
    logic       fe;

    // Frame control
    state_e      state_q, state_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  gapcnt_q, gapcnt_d;
    logic        drdy_q, drdy_d;
    logic [3:0]  dout_q, dout_d;
    logic        overrun_q, overrun_d;
    logic [31:0] frames_q, frames_d;

    // Lane shift registers (datapath, not reset)
    logic [3:0][63:0] lane_q, lane_d;
    logic [3:0][63:0] frame_in;

    // One channel pair on a lane: two 32-bit words, each with its channel index header.
    function automatic logic [63:0] lane_word(input logic [2:0]  idx_a,
                                              input logic [23:0] data_a,
                                              input logic [2:0]  idx_b,
                                              input logic [23:0] data_b);
        return {5'b0, idx_a, data_a, 5'b0, idx_b, data_b};
    endfunction

    // The falling-edge event: this clk edge drives dclk from 1 to 0.
    assign fe = dclk_q && (div_cnt_q == DIV_LAST);

    // Assemble the four lane words from the current channel inputs.
    always_comb begin
        frame_in    = '0;
        frame_in[0] = lane_word(3'd0, ch1_i, 3'd1, ch2_i);
        frame_in[1] = lane_word(3'd2, ch3_i, 3'd3, ch4_i);
        frame_in[2] = lane_word(3'd4, ch5_i, 3'd5, ch6_i);
        frame_in[3] = lane_word(3'd6, ch7_i, 3'd7, ch8_i);
    end

    // Free-running half-period counter; dclk toggles when the counter wraps.
    always_comb begin
        div_cnt_d = div_cnt_q + 8'd1;
        dclk_d    = dclk_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            dclk_d    = ~dclk_q;
        end
    end

    // Frame FSM: next state, shift-register updates and registered outputs.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        bitcnt_d  = bitcnt_q;
        gapcnt_d  = gapcnt_q;
        drdy_d    = drdy_q;
        dout_d    = dout_q;
        overrun_d = overrun_q;
        frames_d  = frames_q;

        // A tick is only accepted from IDLE; anything else is remembered as overrun.
        if (tick_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                drdy_d = 1'b0;
                dout_d = '0;
                if (tick_i) begin
                    lane_d  = frame_in;
                    state_d = ST_PEND;
                end
            end

            ST_PEND: begin
                // First bit and drdy go out together on the next falling edge.
                if (fe) begin
                    drdy_d   = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        dout_d[k] = lane_q[k][63];
                    end
                    bitcnt_d = 6'd63;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (fe) begin
                    drdy_d = 1'b0;
                    if (bitcnt_q != 6'd0) begin
                        for (int k = 0; k < 4; k++) begin
                            lane_d[k] = lane_q[k] << 1;
                            dout_d[k] = lane_q[k][62];
                        end
                        bitcnt_d = bitcnt_q - 6'd1;
                    end else begin
                        // Last bit has had its full period; frame is complete.
                        dout_d   = '0;
                        frames_d = frames_q + 32'd1;
                        if (GAP_DCLK == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            gapcnt_d = GAP_INIT;
                            state_d  = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                drdy_d = 1'b0;
                dout_d = '0;
                if (fe) begin
                    if (gapcnt_q <= 8'd1) begin
                        gapcnt_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        gapcnt_d = gapcnt_q - 8'd1;
                    end
                end
            end

            default: begin
                drdy_d  = 1'b0;
                dout_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_cnt_q <= '0;
            dclk_q    <= 1'b0;
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            gapcnt_q  <= '0;
            drdy_q    <= 1'b0;
            dout_q    <= '0;
            overrun_q <= 1'b0;
            frames_q  <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            dclk_q    <= dclk_d;
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            gapcnt_q  <= gapcnt_d;
            drdy_q    <= drdy_d;
            dout_q    <= dout_d;
            overrun_q <= overrun_d;
            frames_q  <= frames_d;
        end
    end

    // Lane shift registers carry only data, so they are loaded/shifted without reset.
    always_ff @(posedge clk_i) begin
        lane_q <= lane_d;
    end

    assign ready_o   = (state_q == ST_IDLE);
    assign drdy_o    = drdy_q;
    assign dclk_o    = dclk_q;
    assign dout_o    = dout_q;
    assign overrun_o = overrun_q;
    assign frames_o  = frames_q;

endmodule

// File: tb/tb_adc_dout_emulator.sv
// tb_adc_dout_emulator
// Directed bench for adc_dout_emulator with CLK_DIV=2, GAP_DCLK=4. An
// edge-indexed model predicts every output each cycle; a small receiver
// rebuilds lane words on DCLK rising edges for literal frame checks.
module tb_adc_dout_emulator;

    localparam int C = 2;
    localparam int G = 4;
    localparam int P = 2 * C;

    logic               clk = 1'b0;
    logic               reset_ni = 1'b0;
    logic               tick = 1'b0;
    logic signed [23:0] ch [8];
    logic               ready_o, drdy_o, dclk_o, overrun_o;
    logic [3:0]         dout_o;
    logic [31:0]        frames_o;

    int errors = 0;
    int checks = 0;

    adc_dout_emulator #(.CLK_DIV(C), .GAP_DCLK(G)) dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .tick_i    (tick),
        .ch1_i     (ch[0]),
        .ch2_i     (ch[1]),
        .ch3_i     (ch[2]),
        .ch4_i     (ch[3]),
        .ch5_i     (ch[4]),
        .ch6_i     (ch[5]),
        .ch7_i     (ch[6]),
        .ch8_i     (ch[7]),
        .ready_o   (ready_o),
        .drdy_o    (drdy_o),
        .dclk_o    (dclk_o),
        .dout_o    (dout_o),
        .overrun_o (overrun_o),
        .frames_o  (frames_o)
    );

    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_lane(input int l, input logic [23:0] a, input logic [23:0] b);
        return {5'b0, 3'(2 * l), a, 5'b0, 3'(2 * l + 1), b};
    endfunction

    // ---------------- behavioural model (edge-indexed) ----------------
    longint      k = 0;          // clk edges since reset release
    bit          m_active = 0;
    longint      m_f1 = 0;       // edge of first falling DCLK of current frame
    longint      m_busy = 0;     // edge at which ready returns
    logic [63:0] m_lane [4];
    int unsigned m_frames = 0;
    bit          m_ovr = 0;

    task automatic model_step();
        bit ready_before;
        if (!reset_ni) begin
            k = 0; m_active = 0; m_frames = 0; m_ovr = 0;
        end else begin
            k++;
            ready_before = !(m_active && (k - 1) < m_busy);
            if (tick) begin
                if (ready_before) begin
                    for (int l = 0; l < 4; l++) m_lane[l] = exp_lane(l, ch[2 * l], ch[2 * l + 1]);
                    m_f1     = (k / P + 1) * P;
                    m_busy   = m_f1 + (64 + G) * P;
                    m_active = 1;
                end else begin
                    m_ovr = 1;
                end
            end
            if (m_active && k == m_f1 + 64 * P) m_frames++;
        end
    endtask

    task automatic model_outputs(output logic [39:0] e);
        logic       e_rdy, e_drdy, e_dclk;
        logic [3:0] e_dout;
        longint     j;
        e_rdy = 1'b1; e_drdy = 1'b0; e_dclk = 1'b0; e_dout = '0;
        if (reset_ni) begin
            e_dclk = 1'((k / C) % 2);
            e_rdy  = !(m_active && k < m_busy);
            if (m_active && k >= m_f1 && k < m_f1 + 64 * P) begin
                j      = (k - m_f1) / P;
                e_drdy = (j == 0);
                for (int l = 0; l < 4; l++) e_dout[l] = m_lane[l][63 - j];
            end
        end
        e = {e_rdy, e_drdy, e_dclk, e_dout, m_ovr, m_frames};
    endtask

    // ---------------- per-cycle compare ----------------
    longint cyc = 0;
    longint t_fr = 0, t_rdy = 0;
    int     drdy_cyc = 0;
    logic   prev_rdy = 1'b1;
    logic [31:0] prev_frames = '0;

    initial begin
        logic [39:0] act, exp;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            cyc++;
            act = {ready_o, drdy_o, dclk_o, dout_o, overrun_o, frames_o};
            model_outputs(exp);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t {rdy,drdy,dclk,dout,ovr,frames} got %h expected %h",
                         $time, act, exp);
            end
            if (drdy_o === 1'b1) drdy_cyc++;
            if (frames_o !== prev_frames) t_fr = cyc;
            if (ready_o === 1'b1 && prev_rdy === 1'b0) t_rdy = cyc;
            prev_frames = frames_o;
            prev_rdy    = ready_o;
        end
    end

    // ---------------- receiver: sample on DCLK rising edges ----------------
    int          rx_cnt = 0;
    int          rx_count = 0;
    int          rx_drdy = 0;
    logic [63:0] rx_acc  [4];
    logic [63:0] rx_last [4];

    initial begin
        forever begin
            @(posedge dclk_o);
            if (reset_ni) begin
                if (drdy_o) begin
                    rx_drdy++;
                    rx_cnt = 1;
                    for (int l = 0; l < 4; l++) rx_acc[l] = {63'b0, dout_o[l]};
                end else if (rx_cnt > 0 && rx_cnt < 64) begin
                    for (int l = 0; l < 4; l++) rx_acc[l] = {rx_acc[l][62:0], dout_o[l]};
                    rx_cnt++;
                    if (rx_cnt == 64) begin
                        for (int l = 0; l < 4; l++) rx_last[l] = rx_acc[l];
                        rx_count++;
                        rx_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge reset_ni);
            rx_cnt = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        repeat (10) @(negedge clk);
        reset_ni = 1'b1;
    endtask

    task automatic send_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        int c = 0;
        while (rx_count < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_int(name, (rx_count >= n) ? 1 : 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int          toggles, base, c;
        logic        prev;
        logic signed [23:0] v;
        logic [23:0] a_set [8];
        logic [23:0] b_set [8];

        for (int i = 0; i < 8; i++) ch[i] = '0;

        // Reset / idle
        repeat (10) @(negedge clk);
        check_int("rst_dclk", int'(dclk_o), 0);
        check_int("rst_drdy", int'(drdy_o), 0);
        check_int("rst_dout", int'(dout_o), 0);
        check_int("rst_ready", int'(ready_o), 1);
        check_int("rst_frames", int'(frames_o), 0);
        check_int("rst_overrun", int'(overrun_o), 0);
        reset_ni = 1'b1;
        toggles = 0;
        prev = dclk_o;
        repeat (20) begin
            @(negedge clk);
            if (dclk_o !== prev) toggles++;
            prev = dclk_o;
        end
        check_int("dclk_toggles_20clk", toggles, 10);

        // Single frame
        do_reset();
        ch[0] = 24'h123456; ch[1] = 24'hFEDCBA;
        for (int i = 2; i < 8; i++) ch[i] = 24'(i - 1);
        base = rx_count;
        drdy_cyc = 0;
        send_tick();
        wait_rx(base + 1, 2000, "single_rx_timeout");
        repeat (30) @(negedge clk);
        check64("single_lane0", rx_last[0], 64'h00123456_01FEDCBA);
        check64("single_lane1", rx_last[1], 64'h02000001_03000002);
        check64("single_lane3", rx_last[3], 64'h06000005_07000006);
        check_int("single_drdy_clk", drdy_cyc, 4);
        check_int("single_frames", int'(frames_o), 1);
        check_int("single_ready", int'(ready_o), 1);
        check_int("single_gap_clk", int'(t_rdy - t_fr), 16);

        // Loopback-style decode
        ch[0] = 24'hFFFFFF; ch[3] = 24'h7FFFFF; ch[1] = 24'h000010; ch[2] = 24'h800000;
        base = rx_count;
        c = rx_drdy;
        send_tick();
        wait_rx(base + 1, 2000, "loop_rx_timeout");
        repeat (30) @(negedge clk);
        v = rx_last[0][55:32];
        check_int("loop_ch1", int'(v), -1);
        v = rx_last[1][23:0];
        check_int("loop_ch4", int'(v), 8388607);
        v = rx_last[1][55:32];
        check_int("loop_ch3", int'(v), -8388608);
        check_int("loop_ch4_hdr", int'(rx_last[1][31:24]), 3);
        check_int("loop_drdy_per_frame", rx_drdy - c, 1);
        check_int("loop_frames", int'(frames_o), 2);

        // Overrun: second tick 10 clk after the first
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_set[i] = 24'h111111 * 24'(i + 1);
            b_set[i] = 24'hABCDEF ^ 24'(i);
            ch[i] = a_set[i];
        end
        base = rx_count;
        send_tick();
        for (int i = 0; i < 8; i++) ch[i] = b_set[i];
        repeat (8) @(negedge clk);
        send_tick();
        wait_rx(base + 1, 2000, "ovr_rx_timeout");
        repeat (30) @(negedge clk);
        check64("ovr_lane0", rx_last[0], 64'h00111111_01222222);
        check64("ovr_lane2", rx_last[2], exp_lane(2, a_set[4], a_set[5]));
        check_int("ovr_flag", int'(overrun_o), 1);
        check_int("ovr_frames", int'(frames_o), 1);

        // Back-to-back at minimum spacing
        do_reset();
        base = rx_count;
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 8; j++) ch[j] = 24'(i * 8 + j) ^ 24'hA5A5A5;
            send_tick();
            if (i < 99) repeat ((65 + G) * P - 2) @(negedge clk);
        end
        wait_rx(base + 100, 2000, "b2b_rx_timeout");
        repeat (30) @(negedge clk);
        check_int("b2b_frames", int'(frames_o), 100);
        check_int("b2b_overrun", int'(overrun_o), 0);
        check_int("b2b_rx_frames", rx_count - base, 100);
        check64("b2b_last_lane0", rx_last[0], exp_lane(0, 24'(99 * 8) ^ 24'hA5A5A5, 24'(99 * 8 + 1) ^ 24'hA5A5A5));

        // Reset mid-frame at bit 30
        do_reset();
        for (int i = 0; i < 8; i++) ch[i] = 24'h5A5A00 + 24'(i);
        send_tick();
        c = 0;
        while (rx_cnt < 30 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check_int("mid_reached_bit30", (rx_cnt >= 30) ? 1 : 0, 1);
        reset_ni = 1'b0;
        #1;
        check_int("mid_rst_dout", int'(dout_o), 0);
        check_int("mid_rst_drdy", int'(drdy_o), 0);
        check_int("mid_rst_dclk", int'(dclk_o), 0);
        check_int("mid_rst_ready", int'(ready_o), 1);
        repeat (5) @(negedge clk);
        reset_ni = 1'b1;
        for (int i = 0; i < 8; i++) b_set[i] = 24'hC00000 | 24'(i * 3);
        for (int i = 0; i < 8; i++) ch[i] = b_set[i];
        base = rx_count;
        send_tick();
        wait_rx(base + 1, 2000, "mid_rx_timeout");
        repeat (30) @(negedge clk);
        for (int l = 0; l < 4; l++)
            check64($sformatf("mid_lane%0d", l), rx_last[l], exp_lane(l, b_set[2 * l], b_set[2 * l + 1]));
        check_int("mid_frames", int'(frames_o), 1);
        check_int("mid_overrun", int'(overrun_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
